spi_master_shifter: RTL and testbench

//  SPI master shift engine directly downstream of the Avalon SPI control slave. On a one-clk go_transfer

---
 rtl/spi_master_shifter_pkg.sv | 23 ++
 rtl/spi_master_shifter_if.sv | 36 +++
 rtl/spi_master_shifter_clk_gen.sv | 70 +++++++
 rtl/spi_master_shifter.sv | 153 +++++++++++++++
 tb/tb_spi_master_shifter.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_master_shifter_pkg.sv
// Shared definitions for the SPI master shift engine: FSM encoding, SPI mode
// constants shared with the Avalon control slave, and a sizing helper.
package spi_master_shifter_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StSetup = 2'd1,
    StShift = 2'd2,
    StHold  = 2'd3
  } spi_state_e;

  // SPI modes encoded as {CPOL, CPHA}.
  localparam logic [1:0] SpiMode0 = 2'b00;
  localparam logic [1:0] SpiMode1 = 2'b01;
  localparam logic [1:0] SpiMode2 = 2'b10;
  localparam logic [1:0] SpiMode3 = 2'b11;

  // Edge counter must hold 2*data_w without wrapping inside a frame.
  function automatic int unsigned edge_cnt_width(input int unsigned data_w);
    return $clog2(2 * data_w) + 1;
  endfunction

endpackage

// File: rtl/spi_master_shifter_if.sv
// Bus between the Avalon SPI control slave and the shift engine, plus the SPI pins.
// The shift engine uses the slave modport; the control side / SPI device uses master.
interface spi_master_shifter_if #(
  parameter int unsigned DATA_W = 32
);
  logic              go_transfer;
  logic [DATA_W-1:0] data_write_to_spi;
  logic [DATA_W-1:0] data_read_from_spi;
  logic              data_pack_ready;
  logic              spi_sclk;
  logic              spi_mosi;
  logic              spi_miso;
  logic              spi_cs_n;

  modport slave (
    input  go_transfer,
    input  data_write_to_spi,
    input  spi_miso,
    output data_read_from_spi,
    output data_pack_ready,
    output spi_sclk,
    output spi_mosi,
    output spi_cs_n
  );

  modport master (
    output go_transfer,
    output data_write_to_spi,
    output spi_miso,
    input  data_read_from_spi,
    input  data_pack_ready,
    input  spi_sclk,
    input  spi_mosi,
    input  spi_cs_n
  );
endinterface

// File: rtl/spi_master_shifter_clk_gen.sv
// SCLK divider and edge counter. Held at reload while disabled so every frame
// starts with a full half-period before the first SCLK edge.
module spi_master_shifter_clk_gen
  import spi_master_shifter_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned CLK_DIV = 2,
  parameter bit          CPOL    = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  output logic sclk,
  output logic lead_pulse,
  output logic trail_pulse,
  output logic first_edge,
  output logic last_edge
);
  localparam int unsigned EdgeW = edge_cnt_width(DATA_W);
  localparam int unsigned DivW  = $clog2(CLK_DIV) + 1;
  localparam logic [DivW-1:0]  DivLoad  = DivW'(CLK_DIV - 1);
  localparam logic [EdgeW-1:0] LastEdge = EdgeW'(2 * DATA_W - 1);

  logic [DivW-1:0]  div_q, div_d;
  logic [EdgeW-1:0] edge_cnt_q, edge_cnt_d;
  logic             sclk_q, sclk_d;
  logic             tick;

  // An SCLK edge happens on the clk edge that ends a cycle with tick set.
  assign tick = en && (div_q == '0);

  // Divider countdown, SCLK toggle and edge counting.
  always_comb begin
    div_d      = div_q;
    edge_cnt_d = edge_cnt_q;
    sclk_d     = sclk_q;
    if (!en) begin
      div_d      = DivLoad;
      edge_cnt_d = '0;
      sclk_d     = CPOL;
    end else if (tick) begin
      div_d      = DivLoad;
      edge_cnt_d = edge_cnt_q + 1'b1;
      sclk_d     = ~sclk_q;
    end else begin
      div_d = div_q - 1'b1;
    end
  end

  // Divider and SCLK state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q      <= '0;
      edge_cnt_q <= '0;
      sclk_q     <= CPOL;
    end else begin
      div_q      <= div_d;
      edge_cnt_q <= edge_cnt_d;
      sclk_q     <= sclk_d;
    end
  end

  // Even edge indices are leading edges, odd ones trailing.
  assign sclk        = sclk_q;
  assign lead_pulse  = tick && !edge_cnt_q[0];
  assign trail_pulse = tick && edge_cnt_q[0];
  assign first_edge  = tick && (edge_cnt_q == '0);
  assign last_edge   = tick && (edge_cnt_q == LastEdge);

endmodule

// File: rtl/spi_master_shifter.sv
// SPI master shift engine: one frame per go_transfer pulse, full duplex, MSB first.
// data_pack_ready falls on the same edge that updates data_read_from_spi and raises cs_n.
module spi_master_shifter
  import spi_master_shifter_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned CS_SETUP = 2,
  parameter int unsigned CS_HOLD  = 2,
  parameter bit          CPOL     = 1'b0,
  parameter bit          CPHA     = 1'b0
) (
  input logic                clk,
  input logic                reset_n,
  spi_master_shifter_if.slave bus
);
  localparam int unsigned CntMax = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam logic [CntW-1:0] SetupLoad = CntW'(CS_SETUP - 1);
  localparam logic [CntW-1:0] HoldLoad  = CntW'(CS_HOLD - 1);

  spi_state_e        state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic [DATA_W-1:0] rx_q, rx_d;
  logic [DATA_W-1:0] rd_q, rd_d;
  logic              mosi_q, mosi_d;
  logic              cs_n_q, cs_n_d;
  logic              ready_q, ready_d;
  logic              sync1_q, sync2_q;
  logic [1:0]        pipe_q, pipe_d;

  logic sclk, lead_pulse, trail_pulse, first_edge, last_edge;
  logic sample_pulse, shift_pulse;

  spi_master_shifter_clk_gen #(
    .DATA_W  (DATA_W),
    .CLK_DIV (CLK_DIV),
    .CPOL    (CPOL)
  ) u_clk_gen (
    .clk         (clk),
    .reset_n     (reset_n),
    .en          (state_q == StShift),
    .sclk        (sclk),
    .lead_pulse  (lead_pulse),
    .trail_pulse (trail_pulse),
    .first_edge  (first_edge),
    .last_edge   (last_edge)
  );

  // CPHA=1 repeats the MSB on the first leading edge instead of shifting.
  assign sample_pulse = CPHA ? trail_pulse : lead_pulse;
  assign shift_pulse  = CPHA ? (lead_pulse && !first_edge) : trail_pulse;

  // FSM next state plus shift-register and output updates.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    rd_d    = rd_q;
    mosi_d  = mosi_q;
    cs_n_d  = cs_n_q;
    ready_d = ready_q;
    // Sample pulses trail the SCLK edge by the synchroniser depth, so rx takes the
    // MISO level that was present at the edge itself.
    pipe_d  = {pipe_q[0], sample_pulse};

    if (pipe_q[1]) begin
      rx_d = {rx_q[DATA_W-2:0], sync2_q};
    end
    if (shift_pulse) begin
      tx_d   = tx_q << 1;
      mosi_d = tx_q[DATA_W-2];
    end

    unique case (state_q)
      StIdle: begin
        if (bus.go_transfer) begin
          state_d = StSetup;
          cnt_d   = SetupLoad;
          tx_d    = bus.data_write_to_spi;
          mosi_d  = bus.data_write_to_spi[DATA_W-1];
          cs_n_d  = 1'b0;
          ready_d = 1'b1;
          pipe_d  = '0;
        end
      end
      StSetup: begin
        if (cnt_q == '0) begin
          state_d = StShift;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StShift: begin
        if (last_edge) begin
          state_d = StHold;
          cnt_d   = HoldLoad;
        end
      end
      StHold: begin
        if (cnt_q == '0) begin
          state_d = StIdle;
          cs_n_d  = 1'b1;
          ready_d = 1'b0;
          pipe_d  = '0;
          // A sample still one stage short of rx is folded in straight from sync1.
          rd_d    = pipe_q[0] ? {rx_d[DATA_W-2:0], sync1_q} : rx_d;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State, datapath and output registers; reset aborts any frame in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      rd_q    <= '0;
      mosi_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      ready_q <= 1'b0;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      pipe_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      rd_q    <= rd_d;
      mosi_q  <= mosi_d;
      cs_n_q  <= cs_n_d;
      ready_q <= ready_d;
      sync1_q <= bus.spi_miso;
      sync2_q <= sync1_q;
      pipe_q  <= pipe_d;
    end
  end

  assign bus.spi_sclk           = sclk;
  assign bus.spi_mosi           = mosi_q;
  assign bus.spi_cs_n           = cs_n_q;
  assign bus.data_pack_ready    = ready_q;
  assign bus.data_read_from_spi = rd_q;

endmodule

// File: tb/tb_spi_master_shifter.sv
// Scoreboard bench: a mode-0 instance (loopback or MISO tied high) and a mode-3
// instance talking to a behavioural SPI slave.
module tb_spi_master_shifter;
  import spi_master_shifter_pkg::*;

  localparam int unsigned W        = 32;
  localparam int unsigned FrameLen = 2 + 2 * W * 2 + 2;
  localparam int unsigned NumEdges = 2 * W;

  typedef struct {
    logic [W-1:0] tx;
    logic [W-1:0] rx;
  } frame_t;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  spi_master_shifter_if #(.DATA_W(W)) bus0 ();
  spi_master_shifter_if #(.DATA_W(W)) bus3 ();

  spi_master_shifter #(
    .DATA_W(W), .CLK_DIV(2), .CS_SETUP(2), .CS_HOLD(2),
    .CPOL(SpiMode0[1]), .CPHA(SpiMode0[0])
  ) u_dut0 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus0.slave)
  );

  spi_master_shifter #(
    .DATA_W(W), .CLK_DIV(2), .CS_SETUP(2), .CS_HOLD(2),
    .CPOL(SpiMode3[1]), .CPHA(SpiMode3[0])
  ) u_dut3 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus3.slave)
  );

  int n_vec = 0;
  int n_err = 0;
  frame_t q0[$];
  frame_t q3[$];
  int started0 = 0;
  int frames0  = 0;
  int frames3  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Mode-0 device side: MOSI looped back, or MISO held high.
  logic tie0;
  assign bus0.spi_miso = tie0 ? 1'b1 : bus0.spi_mosi;

  // Mode-3 slave: drives MISO on leading (falling) edges, captures MOSI on trailing ones.
  logic [W-1:0] slave_word;
  logic [W-1:0] slave_rx = '0;
  logic         miso3 = 1'b0;
  logic         s3_cs_prev = 1'b1;
  logic         s3_sclk_prev = 1'b1;
  int           s3_idx = 0;
  assign bus3.spi_miso = miso3;

  always @(bus3.spi_sclk or bus3.spi_cs_n) begin
    if (bus3.spi_cs_n === 1'b0 && s3_cs_prev !== 1'b0) begin
      s3_idx   = 0;
      slave_rx = '0;
    end
    if (bus3.spi_cs_n === 1'b0 && bus3.spi_sclk !== s3_sclk_prev) begin
      if (bus3.spi_sclk === 1'b0) begin
        if (s3_idx < W) miso3 = slave_word[W-1-s3_idx];
        s3_idx++;
      end else begin
        slave_rx = {slave_rx[W-2:0], bus3.spi_mosi};
      end
    end
    s3_cs_prev   = bus3.spi_cs_n;
    s3_sclk_prev = bus3.spi_sclk;
  end

  // Monitor for the mode-0 instance.
  logic         m0_prev_ready = 1'b0;
  logic         m0_prev_sclk = 1'b0;
  int           m0_len = 0;
  int           m0_edges = 0;
  logic [W-1:0] m0_mosi_word = '0;

  always @(negedge clk) begin
    frame_t f;
    if (reset_n !== 1'b1) begin
      m0_prev_ready = 1'b0;
      m0_prev_sclk  = bus0.spi_sclk;
      m0_len        = 0;
      m0_edges      = 0;
      m0_mosi_word  = '0;
    end else begin
      check("cs_n_vs_ready0", bus0.spi_cs_n, !bus0.data_pack_ready);
      if (bus0.spi_sclk !== m0_prev_sclk) m0_edges++;
      if (m0_prev_sclk === 1'b0 && bus0.spi_sclk === 1'b1)
        m0_mosi_word = {m0_mosi_word[W-2:0], bus0.spi_mosi};
      if (bus0.data_pack_ready === 1'b1) m0_len++;
      if (m0_prev_ready === 1'b1 && bus0.data_pack_ready === 1'b0) begin
        frames0++;
        n_vec++;
        if (q0.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_frame0: got a completion, want none queued");
        end else begin
          f = q0.pop_front();
          check("read_word0", bus0.data_read_from_spi, f.rx);
          check("mosi_word0", m0_mosi_word, f.tx);
        end
        check("ready_len0", m0_len, FrameLen);
        check("sclk_edges0", m0_edges, NumEdges);
        check("sclk_idle0", bus0.spi_sclk, 1'b0);
        m0_len   = 0;
        m0_edges = 0;
      end
      m0_prev_ready = bus0.data_pack_ready;
      m0_prev_sclk  = bus0.spi_sclk;
    end
  end

  // Monitor for the mode-3 instance.
  logic m3_prev_ready = 1'b0;
  int   m3_len = 0;

  always @(negedge clk) begin
    frame_t f;
    if (reset_n !== 1'b1) begin
      m3_prev_ready = 1'b0;
      m3_len        = 0;
    end else begin
      if (bus3.data_pack_ready === 1'b1) m3_len++;
      if (m3_prev_ready === 1'b1 && bus3.data_pack_ready === 1'b0) begin
        frames3++;
        n_vec++;
        if (q3.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_frame3: got a completion, want none queued");
        end else begin
          f = q3.pop_front();
          check("read_word3", bus3.data_read_from_spi, f.rx);
          check("slave_capture3", slave_rx, f.tx);
        end
        check("ready_len3", m3_len, FrameLen);
        check("sclk_idle3", bus3.spi_sclk, 1'b1);
        check("cs_n_rise3", bus3.spi_cs_n, 1'b1);
        m3_len = 0;
      end
      m3_prev_ready = bus3.data_pack_ready;
    end
  end

  // Issues a go pulse in the current cycle; data is scrambled right after the go cycle.
  task automatic start0(input logic [W-1:0] word, input logic tie);
    frame_t f;
    tie0 = tie;
    f.tx = word;
    f.rx = tie ? '1 : word;
    q0.push_back(f);
    started0++;
    bus0.data_write_to_spi = word;
    bus0.go_transfer = 1'b1;
    @(negedge clk);
    bus0.go_transfer = 1'b0;
    bus0.data_write_to_spi = $urandom;
  endtask

  task automatic start3(input logic [W-1:0] word);
    frame_t f;
    f.tx = word;
    f.rx = slave_word;
    q3.push_back(f);
    bus3.data_write_to_spi = word;
    bus3.go_transfer = 1'b1;
    @(negedge clk);
    bus3.go_transfer = 1'b0;
    bus3.data_write_to_spi = $urandom;
  endtask

  // Returns on the first negedge with data_pack_ready low, or after a cycle budget.
  task automatic wait_done(input int sel);
    int n = 0;
    while (((sel == 0) ? bus0.data_pack_ready : bus3.data_pack_ready) === 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    n_vec++;
    if (n >= 400) begin
      n_err++;
      $display("FAIL frame_timeout%0d: got %0d cycles busy, want at most %0d", sel, n, FrameLen);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by %0t, want finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0;
    tie0 = 1'b0;
    slave_word = '0;
    bus0.go_transfer = 1'b0;
    bus0.data_write_to_spi = '0;
    bus3.go_transfer = 1'b0;
    bus3.data_write_to_spi = '0;
    repeat (3) @(negedge clk);

    check("rst_cs_n0", bus0.spi_cs_n, 1'b1);
    check("rst_sclk0", bus0.spi_sclk, 1'b0);
    check("rst_mosi0", bus0.spi_mosi, 1'b0);
    check("rst_ready0", bus0.data_pack_ready, 1'b0);
    check("rst_read0", bus0.data_read_from_spi, '0);
    check("rst_sclk3", bus3.spi_sclk, 1'b1);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Loopback, mode 0.
    start0(32'hA5A5_0F0F, 1'b0);
    wait_done(0);
    @(negedge clk);

    // MISO tied high, all-zero word.
    start0(32'h0000_0000, 1'b1);
    wait_done(0);
    @(negedge clk);

    // Mode 3 against the slave model.
    slave_word = 32'h1234_5678;
    start3(32'hC3A5_9E01);
    wait_done(3);
    @(negedge clk);
    slave_word = $urandom;
    start3($urandom);
    wait_done(3);
    @(negedge clk);

    // A second go 40 cycles in must be ignored.
    start0(32'h0F1E_2D3C, 1'b0);
    repeat (39) @(negedge clk);
    bus0.data_write_to_spi = 32'hDEAD_BEEF;
    bus0.go_transfer = 1'b1;
    @(negedge clk);
    bus0.go_transfer = 1'b0;
    wait_done(0);
    @(negedge clk);

    // Reset 70 cycles into a frame.
    start0($urandom, 1'b0);
    repeat (69) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("abort_cs_n", bus0.spi_cs_n, 1'b1);
    check("abort_sclk", bus0.spi_sclk, 1'b0);
    check("abort_ready", bus0.data_pack_ready, 1'b0);
    check("abort_read", bus0.data_read_from_spi, '0);
    q0.delete();
    started0--;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    start0($urandom, 1'b0);
    wait_done(0);
    @(negedge clk);

    // Back-to-back frames: go on the first idle cycle.
    start0(32'h0000_0001, 1'b0);
    wait_done(0);
    check("b2b_gap_cs_high", bus0.spi_cs_n, 1'b1);
    start0(32'h8000_0000, 1'b0);
    check("b2b_gap_one_cycle", bus0.spi_cs_n, 1'b0);
    wait_done(0);
    @(negedge clk);

    // Random words, random MISO source, random gaps including back-to-back.
    for (int i = 0; i < 8; i++) begin
      start0($urandom, 1'($urandom_range(0, 1)));
      wait_done(0);
      if ($urandom_range(0, 2) != 0) repeat ($urandom_range(1, 4)) @(negedge clk);
    end
    repeat (3) @(negedge clk);

    check("q0_drained", q0.size(), 0);
    check("q3_drained", q3.size(), 0);
    check("frames0_count", frames0, started0);
    check("frames3_count", frames3, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
